// File: rtl/mult_div_ctrl_pkg.sv
// Shared definitions for the mult/div sequencer: controller states,
// operation encodings and the default datapath width.
package mult_div_ctrl_pkg;

    localparam int MD_DATA_W = 32;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        WRITE,
        EXC,
        TERR
    } md_state_e;

endpackage

// File: rtl/md_watchdog.sv
// RUN-state watchdog for the mult/div sequencer. The counter is cleared on
// entry to RUN, counts while enabled and flags expiry in the cycle where
// LIMIT RUN cycles have elapsed without completion.
// Only present when MD_TIMEOUT_EN is defined.
`ifdef MD_TIMEOUT_EN
module md_watchdog #(
    parameter int LIMIT = 40
) (
    input  logic clock,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear wins, otherwise count up while enabled, saturating at LIMIT
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i && (count_q != CW'(LIMIT))) begin
            count_d = count_q + CW'(1);
        end
    end

    // Counter register with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire_o = enable_i && (count_q == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mult_div_ctrl.sv
// Sequencer between the CPU control unit and the shared mult/div datapath.
// Latches one MULT/DIV request, pulses the datapath reset, holds the mode
// until the datapath reports completion, then writes HI/LO. A divide with a
// zero divisor is trapped without starting the datapath.
// Optional feature: define MD_TIMEOUT_EN to add a RUN-state watchdog that
// retires a hung operation through the TERR state.
module mult_div_ctrl
    import mult_div_ctrl_pkg::*;
#(
    parameter int DATA_W         = MD_DATA_W,
    parameter int TIMEOUT_CYCLES = 40
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              op,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic              busy,
    output logic              done,
    output logic              div_by_zero,
    output logic              timeout_err,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo,
    output logic              md_hd_control,
    output logic [DATA_W-1:0] md_a,
    output logic [DATA_W-1:0] md_b,
    output logic              md_reset,
    input  logic [DATA_W-1:0] md_hi,
    input  logic [DATA_W-1:0] md_lo,
    input  logic              md_done
);

    md_state_e         state_q, state_d;
    logic              op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic              runFirst_q, runFirst_d;
    logic              wdExpire;

`ifdef MD_TIMEOUT_EN
    md_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock   (clock),
        .reset   (reset),
        .clear_i (state_q == CLEAR),
        .enable_i(state_q == RUN),
        .expire_o(wdExpire)
    );
`else
    logic [31:0] unusedTimeout;
    assign unusedTimeout = 32'(TIMEOUT_CYCLES);
    assign wdExpire      = 1'b0;
`endif

    // Next-state logic: request acceptance, datapath sequencing and HI/LO capture
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        runFirst_d = (state_q == CLEAR);
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = a_in;
                    b_d  = b_in;
                    if ((op == OP_DIV) && (b_in == '0)) begin
                        state_d = EXC;
                    end else begin
                        state_d = CLEAR;
                    end
                end
            end
            CLEAR: begin
                state_d = RUN;
            end
            RUN: begin
                if (md_done && !runFirst_q) begin
                    hi_d    = md_hi;
                    lo_d    = md_lo;
                    state_d = WRITE;
                end else if (wdExpire) begin
                    state_d = TERR;
                end
            end
            WRITE: begin
                state_d = IDLE;
            end
            EXC: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latched request and architectural HI/LO registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_MULT;
            a_q        <= '0;
            b_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            runFirst_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            runFirst_q <= runFirst_d;
        end
    end

    // Status outputs decoded from the state register
    always_comb begin
        busy        = (state_q != IDLE);
        done        = (state_q == WRITE) || (state_q == EXC) || (state_q == TERR);
        div_by_zero = (state_q == EXC);
`ifdef MD_TIMEOUT_EN
        timeout_err = (state_q == TERR);
`else
        timeout_err = 1'b0;
`endif
        md_reset    = reset || (state_q != RUN);
    end

    assign hi            = hi_q;
    assign lo            = lo_q;
    assign md_hd_control = op_q;
    assign md_a          = a_q;
    assign md_b          = b_q;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed testbench for mult_div_ctrl with a behavioural mult/div datapath.
// The datapath model holds a stale Done through its reset and into the
// first RUN cycle, then raises Done DP_LAT cycles after release.
module tb_mult_div_ctrl;

    localparam int DP_LAT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic        timeout_err;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        md_hd_control;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_reset;
    logic [31:0] md_hi;
    logic [31:0] md_lo;
    logic        md_done;

    int          errors = 0;
    int          checks = 0;
    int          dpCnt;
    logic        holdDone;
    logic        useForce;
    logic [31:0] forceHi;
    logic [31:0] forceLo;
    logic        modeBad;
    logic        relSeen;
    int          ticks;
    int          pulses;
    logic        dbzSeen;

    mult_div_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .op           (op),
        .a_in         (a_in),
        .b_in         (b_in),
        .busy         (busy),
        .done         (done),
        .div_by_zero  (div_by_zero),
        .timeout_err  (timeout_err),
        .hi           (hi),
        .lo           (lo),
        .md_hd_control(md_hd_control),
        .md_a         (md_a),
        .md_b         (md_b),
        .md_reset     (md_reset),
        .md_hi        (md_hi),
        .md_lo        (md_lo),
        .md_done      (md_done)
    );

    always #5 clock = ~clock;

    // Datapath completion model
    always @(posedge clock) begin
        if (md_reset) begin
            dpCnt   <= 0;
            md_done <= 1'b1;
        end else begin
            dpCnt   <= dpCnt + 1;
            md_done <= !holdDone && ((dpCnt + 1) == DP_LAT);
        end
    end

    // Datapath result model: signed multiply or signed divide
    logic signed [63:0] prod;
    always_comb begin
        prod  = $signed({{32{md_a[31]}}, md_a}) * $signed({{32{md_b[31]}}, md_b});
        md_hi = prod[63:32];
        md_lo = prod[31:0];
        if (md_hd_control) begin
            if (md_b == 32'd0) begin
                md_hi = md_a;
                md_lo = 32'hFFFF_FFFF;
            end else begin
                md_hi = $signed(md_a) % $signed(md_b);
                md_lo = $signed(md_a) / $signed(md_b);
            end
        end
        if (useForce) begin
            md_hi = forceHi;
            md_lo = forceLo;
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one request for one cycle, then scramble the operand inputs
    task automatic applyStimulus(input logic opV, input logic [31:0] aV, input logic [31:0] bV);
        step();
        start = 1'b1;
        op    = opV;
        a_in  = aV;
        b_in  = bV;
        step();
        start = 1'b0;
        op    = ~opV;
        a_in  = 32'hDEAD_BEEF;
        b_in  = 32'h0;
    endtask

    // Wait (bounded) for done; ticks counts edges after the accepting edge
    task automatic waitDone(input string tag, input logic expMode);
        logic got;
        got     = 1'b0;
        ticks   = 0;
        modeBad = 1'b0;
        relSeen = 1'b0;
        while (!got && ticks < 200) begin
            if (done) begin
                got = 1'b1;
            end else begin
                if (md_hd_control !== expMode) modeBad = 1'b1;
                if (md_reset === 1'b0) relSeen = 1'b1;
                step();
                ticks++;
            end
        end
        if (!got) checkOutput({tag, "_doneSeen"}, 64'd0, 64'd1);
    endtask

    // Count done pulses and div_by_zero sightings over a fixed window
    task automatic watchWindow(input int cycles);
        pulses  = 0;
        dbzSeen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            if (done) pulses++;
            if (div_by_zero) dbzSeen = 1'b1;
            step();
        end
    endtask

    task automatic runOp(input string tag, input logic opV, input logic [31:0] aV, input logic [31:0] bV,
                         input int expTicks, input logic [31:0] expHi, input logic [31:0] expLo,
                         input logic expDbz);
        applyStimulus(opV, aV, bV);
        checkOutput({tag, "_busy"}, busy, 1);
        waitDone(tag, opV);
        checkOutput({tag, "_ticks"}, ticks, expTicks);
        checkOutput({tag, "_dbz"}, div_by_zero, expDbz);
        checkOutput({tag, "_terr"}, timeout_err, 0);
        checkOutput({tag, "_hi"}, hi, expHi);
        checkOutput({tag, "_lo"}, lo, expLo);
        step();
        checkOutput({tag, "_donePulse"}, done, 0);
        checkOutput({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        op       = 1'b0;
        a_in     = '0;
        b_in     = '0;
        holdDone = 1'b0;
        useForce = 1'b0;
        forceHi  = 32'h1111_1111;
        forceLo  = 32'h2222_2222;
        repeat (3) step();

        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_dbz", div_by_zero, 0);
        checkOutput("rst_terr", timeout_err, 0);
        checkOutput("rst_hi", hi, 0);
        checkOutput("rst_lo", lo, 0);
        checkOutput("rst_mdReset", md_reset, 1);
        checkOutput("rst_mode", md_hd_control, 0);
        checkOutput("rst_mdA", md_a, 0);
        checkOutput("rst_mdB", md_b, 0);
        reset = 1'b0;

        // Unsigned-looking multiply; operands must be latched, not forwarded
        applyStimulus(1'b0, 32'd6, 32'd7);
        checkOutput("mul_clearReset", md_reset, 1);
        checkOutput("mul_latchA", md_a, 6);
        checkOutput("mul_latchB", md_b, 7);
        waitDone("mul", 1'b0);
        checkOutput("mul_ticks", ticks, 6);
        checkOutput("mul_dbz", div_by_zero, 0);
        checkOutput("mul_terr", timeout_err, 0);
        checkOutput("mul_hi", hi, 32'h0000_0000);
        checkOutput("mul_lo", lo, 32'h0000_002A);
        checkOutput("mul_mode", modeBad, 0);
        step();
        checkOutput("mul_donePulse", done, 0);
        checkOutput("mul_idle", busy, 0);

        runOp("smul", 1'b0, 32'hFFFF_FFFD, 32'd5, 6, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);

        runOp("div", 1'b1, 32'd100, 32'd7, 6, 32'd2, 32'd14, 1'b0);
        checkOutput("div_modeHeld", modeBad, 0);

        // Preset HI/LO through a forced datapath result
        useForce = 1'b1;
        runOp("preset", 1'b0, 32'd1, 32'd1, 6, 32'h1111_1111, 32'h2222_2222, 1'b0);
        useForce = 1'b0;

        runOp("dbz", 1'b1, 32'd100, 32'd0, 0, 32'h1111_1111, 32'h2222_2222, 1'b1);
        checkOutput("dbz_mdResetHeld", relSeen, 0);

        // A second start while busy must be ignored
        applyStimulus(1'b0, 32'd6, 32'd7);
        step();
        step();
        start = 1'b1;
        op    = 1'b1;
        a_in  = 32'd100;
        b_in  = 32'd0;
        step();
        start = 1'b0;
        watchWindow(15);
        checkOutput("busyStart_pulses", pulses, 1);
        checkOutput("busyStart_dbz", dbzSeen, 0);
        checkOutput("busyStart_hi", hi, 32'h0);
        checkOutput("busyStart_lo", lo, 32'h2A);

`ifdef MD_TIMEOUT_EN
        // Hung datapath: watchdog retires the operation 40 RUN cycles in
        holdDone = 1'b1;
        applyStimulus(1'b1, 32'd100, 32'd7);
        waitDone("tmo", 1'b1);
        checkOutput("tmo_ticks", ticks, 41);
        checkOutput("tmo_terr", timeout_err, 1);
        checkOutput("tmo_dbz", div_by_zero, 0);
        checkOutput("tmo_hi", hi, 32'h0);
        checkOutput("tmo_lo", lo, 32'h2A);
        step();
        checkOutput("tmo_donePulse", done, 0);
        holdDone = 1'b0;
`endif

        // Reset in the middle of RUN aborts without a result or done
        applyStimulus(1'b1, 32'd100, 32'd7);
        step();
        step();
        step();
        checkOutput("abort_inRun", md_reset, 0);
        reset = 1'b1;
        step();
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_hi", hi, 0);
        checkOutput("abort_lo", lo, 0);
        reset = 1'b0;
        watchWindow(12);
        checkOutput("abort_noDone", pulses, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
